qbus_dma_master: RTL and testbench

//  QBUS bus-master engine: wins DMA arbitration and runs one single-word DATI or DATO cycle
//  per request from the internal DMA client. Sits between the device's DMA logic and qdrv,

---
 rtl/qbus_dma_master_pkg.sv | 50 +++++
 rtl/qbus_dma_master_sync2.sv | 30 +++
 rtl/qbus_dma_master.sv | 188 ++++++++++++++++++
 tb/tb_qbus_dma_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_dma_master_pkg.sv
// ------------------------------------------------------------------------------
// qbus_dma_master_pkg: states, timing defaults and output bundle for the QBUS DMA master. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

package qbus_dma_master_pkg;

  localparam int unsigned SETUP_CYC_DEF  = 3;
  localparam int unsigned HOLD_CYC_DEF   = 2;
  localparam int unsigned DESKEW_CYC_DEF = 3;
  localparam int unsigned NXM_CYC_DEF    = 200;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned NXM_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_REQ     = 4'd1,
    ST_GRANT   = 4'd2,
    ST_ADDR    = 4'd3,
    ST_SYNC    = 4'd4,
    ST_DATA    = 4'd5,
    ST_WAITR   = 4'd6,
    ST_DESKEW  = 4'd7,
    ST_NEGATE  = 4'd8,
    ST_RELEASE = 4'd9
  } state_e;

  typedef struct packed {
    logic tbs7;
    logic twtbt;
    logic tsync;
    logic tdin;
    logic tdout;
    logic tdmr;
    logic tsack;
    logic tdmgo;
    logic daltx;
    logic done;
    logic nxm;
  } qbus_out_t;

  // The I/O page is the top 8 KB of the 22-bit space.
  function automatic logic is_io_page(input logic [21:0] a);
    return a[21:13] == 9'h1FF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qbus_dma_master_sync2.sv
// ------------------------------------------------------------------------------
// qbus_dma_master_sync2: two-flop synchronizer for one asynchronous bus receiver line. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module qbus_dma_master_sync2 (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/qbus_dma_master.sv
// ------------------------------------------------------------------------------
// qbus_dma_master: QBUS DMA bus master, one single-word DATI/DATO per request with NXM timeout. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module qbus_dma_master
  import qbus_dma_master_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = SETUP_CYC_DEF,
  parameter int unsigned HOLD_CYC   = HOLD_CYC_DEF,
  parameter int unsigned DESKEW_CYC = DESKEW_CYC_DEF,
  parameter int unsigned NXM_CYC    = NXM_CYC_DEF
) (
  input  logic        qclk_i,
  input  logic        reset_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [21:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic        done_o,
  output logic        nxm_o,
  output logic [15:0] rdata_o,
  output logic        daltx_o,
  inout  wire  [21:0] dal_io,
  output logic        tbs7_o,
  output logic        twtbt_o,
  output logic        tsync_o,
  output logic        tdin_o,
  output logic        tdout_o,
  output logic        tdmr_o,
  output logic        tsack_o,
  output logic        tdmgo_o,
  input  logic        rrply_i,
  input  logic        rsync_i,
  input  logic        rdmgi_i,
  input  logic        rinit_i
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_NEG  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] DESKEW_LD = CNT_W'(DESKEW_CYC - 1);
  localparam logic [NXM_W-1:0] NXM_LAST  = NXM_W'(NXM_CYC - 1);

  logic [3:0] async_in;
  logic [3:0] sync_out;
  logic       s_rply, s_sync, s_dmgi, s_init;

  assign async_in = {rinit_i, rdmgi_i, rsync_i, rrply_i};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    qbus_dma_master_sync2 u_sync (
      .clk_i     (qclk_i),
      .reset_n_i (reset_n_i),
      .d_i       (async_in[i]),
      .q_o       (sync_out[i])
    );
  end

  assign {s_init, s_dmgi, s_sync, s_rply} = sync_out;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NXM_W-1:0]  nxm_cnt_q, nxm_cnt_d;
  logic              nxm_flag_q, nxm_flag_d;
  logic              we_q;
  logic [21:0]       addr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       rdata_q;
  logic              latch_req, capture;
  qbus_out_t         out_c;
  logic [21:0]       dal_drv;

  always_ff @(posedge qclk_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nxm_cnt_q  <= '0;
      nxm_flag_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nxm_cnt_q  <= nxm_cnt_d;
      nxm_flag_q <= nxm_flag_d;
      if (latch_req) begin
        we_q    <= we_i;
        addr_q  <= addr_i & 22'h3FFFFE;
        wdata_q <= wdata_i;
      end
      if (capture) rdata_q <= dal_io[15:0];
    end
  end

  // One shared phase counter: loaded with N-1 on entry, phase ends when it reads zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    nxm_cnt_d  = nxm_cnt_q;
    nxm_flag_d = nxm_flag_q;
    latch_req  = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE:    if (req_i) begin state_d = ST_REQ; latch_req = 1'b1; end
      ST_REQ:     if (s_dmgi) state_d = ST_GRANT;
      ST_GRANT:   if (!s_sync && !s_rply) begin
                    state_d    = ST_ADDR;
                    cnt_d      = SETUP_LD;
                    nxm_flag_d = 1'b0;
                  end
      ST_ADDR:    if (cnt_q == '0) begin state_d = ST_SYNC; cnt_d = HOLD_LD; end
      ST_SYNC:    if (cnt_q == '0) begin state_d = ST_DATA; cnt_d = SETUP_LD; end
      ST_DATA:    if (!we_q || cnt_q == '0) begin state_d = ST_WAITR; nxm_cnt_d = '0; end
      ST_WAITR:   if (s_rply) begin
                    state_d = we_q ? ST_NEGATE : ST_DESKEW;
                    cnt_d   = we_q ? HOLD_NEG : DESKEW_LD;
                  end else if (nxm_cnt_q == NXM_LAST) begin
                    state_d    = ST_RELEASE;
                    nxm_flag_d = 1'b1;
                  end else begin
                    nxm_cnt_d = nxm_cnt_q + 1'b1;
                  end
      ST_DESKEW:  if (cnt_q == '0) begin capture = 1'b1; state_d = ST_NEGATE; end
      ST_NEGATE:  if (cnt_q == '0 && !s_rply) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (s_init) begin
      state_d   = ST_IDLE;
      latch_req = 1'b0;
      capture   = 1'b0;
    end
  end

  always_comb begin
    out_c   = '0;
    dal_drv = '0;
    case (state_q)
      ST_IDLE:    out_c.tdmgo = s_dmgi;
      ST_REQ:     out_c.tdmr  = 1'b1;
      ST_GRANT:   out_c.tsack = 1'b1;
      ST_ADDR, ST_SYNC: begin
        out_c.tsack = 1'b1;
        out_c.tsync = (state_q == ST_SYNC);
        out_c.daltx = 1'b1;
        out_c.tbs7  = is_io_page(addr_q);
        out_c.twtbt = we_q;
        dal_drv     = addr_q;
      end
      ST_DATA, ST_WAITR: begin
        out_c.tsack = 1'b1;
        out_c.tsync = 1'b1;
        out_c.daltx = we_q;
        out_c.tdin  = (state_q == ST_WAITR) && !we_q;
        out_c.tdout = (state_q == ST_WAITR) && we_q;
        dal_drv     = {6'b0, wdata_q};
      end
      ST_DESKEW: begin
        out_c.tsack = 1'b1;
        out_c.tsync = 1'b1;
        out_c.tdin  = 1'b1;
      end
      ST_NEGATE: begin
        out_c.tsack = 1'b1;
        out_c.tsync = 1'b1;
        out_c.daltx = we_q && (cnt_q != '0);
        dal_drv     = {6'b0, wdata_q};
      end
      ST_RELEASE: begin
        out_c.done = 1'b1;
        out_c.nxm  = nxm_flag_q;
      end
      default: out_c = '0;
    endcase
    if (s_init) out_c = '0;
  end

  assign dal_io  = out_c.daltx ? dal_drv : {22{1'bz}};
  assign rdata_o = rdata_q;
  assign {tbs7_o, twtbt_o, tsync_o, tdin_o, tdout_o, tdmr_o, tsack_o, tdmgo_o,
          daltx_o, done_o, nxm_o} = out_c;

endmodule

`default_nettype wire

// File: tb/tb_qbus_dma_master.sv
// ------------------------------------------------------------------------------
// tb_qbus_dma_master: directed bench with a one-register slave at 'o17777440 and a simple arbiter. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

module tb_qbus_dma_master;

  localparam logic [21:0] SLV_ADDR = 22'o17777440;
  localparam logic [21:0] NXM_IO   = 22'o17777400;
  localparam logic [21:0] NXM_MEM  = 22'o00001000;

  logic        qclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [21:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        done, nxm, daltx;
  logic [15:0] rdata;
  wire  [21:0] dal;
  logic        tbs7, twtbt, tsync, tdin, tdout, tdmr, tsack, tdmgo;
  logic        rrply = 1'b0, rsync = 1'b0, rdmgi = 1'b0, rinit = 1'b0;

  logic        slv_oe = 1'b0;
  logic [21:0] slv_dal = '0;
  logic [15:0] mem = 16'o123456;
  logic [5:0]  wr_hi = '0;
  logic [21:0] addr_lat = '0;
  logic        bs7_lat = 1'b0, wtbt_lat = 1'b0;
  logic        tsync_p = 1'b0, tdout_p = 1'b0, dout_seen = 1'b0, dout_fell = 1'b0;
  int          pre_cnt = 0, post_cnt = 0, tdin_cyc = 0, viol = 0;
  logic        arb_en = 1'b1, arb_force = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #25 qclk = ~qclk;

  assign dal = slv_oe ? slv_dal : {22{1'bz}};

  qbus_dma_master dut (
    .qclk_i   (qclk),   .reset_n_i (reset_n), .req_i   (req),   .we_i    (we),
    .addr_i   (addr),   .wdata_i   (wdata),   .done_o  (done),  .nxm_o   (nxm),
    .rdata_o  (rdata),  .daltx_o   (daltx),   .dal_io  (dal),
    .tbs7_o   (tbs7),   .twtbt_o   (twtbt),   .tsync_o (tsync), .tdin_o  (tdin),
    .tdout_o  (tdout),  .tdmr_o    (tdmr),    .tsack_o (tsack), .tdmgo_o (tdmgo),
    .rrply_i  (rrply),  .rsync_i   (rsync),   .rdmgi_i (rdmgi), .rinit_i (rinit)
  );

  wire [9:0] outs = {tbs7, twtbt, tsync, tdin, tdout, tdmr, tsack, tdmgo, daltx, done};

  // Bus monitor, slave register and arbiter, all acting on the falling edge.
  always @(negedge qclk) begin
    if (tsync && !tsync_p) begin
      addr_lat = dal; bs7_lat = tbs7; wtbt_lat = twtbt;
      pre_cnt = 0; post_cnt = 0; tdin_cyc = 0; dout_seen = 1'b0; dout_fell = 1'b0;
    end
    if (daltx && tsync && !twtbt && !tdout && !dout_seen) pre_cnt++;
    if (tdout) dout_seen = 1'b1;
    if (tdout_p && !tdout) dout_fell = 1'b1;
    if (dout_fell && daltx) post_cnt++;
    if (tdin) tdin_cyc++;
    if ((tdin && tdout) || (tsync && !tsack) || (slv_oe && daltx)) viol++;
    if (tdin && addr_lat == SLV_ADDR) begin
      slv_dal = {6'b0, mem}; slv_oe = 1'b1; rrply = 1'b1;
    end else if (tdout && addr_lat == SLV_ADDR) begin
      if (!rrply) begin mem = dal[15:0]; wr_hi = dal[21:16]; end
      rrply = 1'b1;
    end else begin
      slv_oe = 1'b0; rrply = 1'b0;
    end
    rdmgi   = arb_force | (arb_en & tdmr & ~tsack);
    tsync_p = tsync;
    tdout_p = tdout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin @(negedge qclk); n++; end
    if (n >= 2000) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic w, input logic [21:0] a, input logic [15:0] d, output logic nx);
    @(negedge qclk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge qclk);
    req = 1'b0;
    wait_done();
    nx = nxm;
    @(negedge qclk);
    check_eq("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic nx;
    int   n;
    int   ok;

    repeat (3) @(negedge qclk);
    check_eq("reset_outs", {22'b0, outs}, 32'd0);
    check_eq("reset_rdata", {16'b0, rdata}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge qclk);

    // DATI from the I/O page slave
    xfer(1'b0, SLV_ADDR, 16'h0, nx);
    check_eq("dati_nxm", {31'b0, nx}, 32'd0);
    check_eq("dati_rdata", {16'b0, rdata}, {16'b0, 16'o123456});
    check_eq("dati_bs7", {31'b0, bs7_lat}, 32'd1);
    check_eq("dati_wtbt", {31'b0, wtbt_lat}, 32'd0);
    check_eq("dati_addr", {10'b0, addr_lat}, {10'b0, SLV_ADDR});

    // DATO then DATI back
    xfer(1'b1, SLV_ADDR, 16'o054321, nx);
    check_eq("dato_nxm", {31'b0, nx}, 32'd0);
    check_eq("dato_mem", {16'b0, mem}, {16'b0, 16'o054321});
    check_eq("dato_hi_zero", {26'b0, wr_hi}, 32'd0);
    check_eq("dato_wtbt", {31'b0, wtbt_lat}, 32'd1);
    check_eq("dato_setup", pre_cnt, 32'd3);
    check_eq("dato_hold", post_cnt, 32'd2);
    xfer(1'b0, SLV_ADDR, 16'h0, nx);
    check_eq("readback_rdata", {16'b0, rdata}, {16'b0, 16'o054321});

    // No slave in the I/O page: RPLY timeout
    xfer(1'b0, NXM_IO, 16'h0, nx);
    check_eq("nxm_io_flag", {31'b0, nx}, 32'd1);
    check_eq("nxm_io_din_cycles", tdin_cyc, 32'd200);
    check_eq("nxm_bus_idle", {29'b0, tsync, tsack, daltx}, 32'd0);
    check_eq("nxm_rdata_kept", {16'b0, rdata}, {16'b0, 16'o054321});

    // No slave in memory space, write
    xfer(1'b1, NXM_MEM, 16'hBEEF, nx);
    check_eq("nxm_mem_flag", {31'b0, nx}, 32'd1);
    check_eq("nxm_mem_bs7", {31'b0, bs7_lat}, 32'd0);
    check_eq("nxm_mem_wtbt", {31'b0, wtbt_lat}, 32'd1);

    // Grant withheld for 1 us
    arb_en = 1'b0;
    @(negedge qclk);
    req = 1'b1; we = 1'b0; addr = SLV_ADDR;
    @(negedge qclk);
    req = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge qclk);
      if (tdmr && !tsync && !tsack) ok++;
    end
    check_eq("nogrant_tdmr_held", ok, 32'd20);
    arb_en = 1'b1;
    wait_done();
    check_eq("late_grant_nxm", {31'b0, nxm}, 32'd0);
    @(negedge qclk);

    // req held across done: one IDLE cycle between transfers
    req = 1'b1; we = 1'b0; addr = SLV_ADDR;
    wait_done();
    n = 0;
    do begin @(negedge qclk); n++; end while (!tdmr && n < 10);
    check_eq("b2b_gap", n, 32'd2);
    req = 1'b0;
    wait_done();
    check_eq("b2b_second_nxm", {31'b0, nxm}, 32'd0);
    @(negedge qclk);

    // INIT during WAITR
    @(negedge qclk);
    req = 1'b1; we = 1'b0; addr = NXM_IO;
    @(negedge qclk);
    req = 1'b0;
    n = 0;
    while (!tdin && n < 100) begin @(negedge qclk); n++; end
    check_eq("init_reached_waitr", {31'b0, tdin}, 32'd1);
    repeat (5) @(negedge qclk);
    rinit = 1'b1;
    repeat (3) @(negedge qclk);
    check_eq("init_outs_low", {22'b0, outs}, 32'd0);
    ok = 0;
    for (int i = 0; i < 8; i++) begin @(negedge qclk); if (done) ok++; end
    rinit = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge qclk); if (done) ok++; end
    check_eq("init_no_done", ok, 32'd0);
    xfer(1'b0, SLV_ADDR, 16'h0, nx);
    check_eq("post_init_nxm", {31'b0, nx}, 32'd0);
    check_eq("post_init_rdata", {16'b0, rdata}, {16'b0, 16'o054321});

    // reset_n mid-DATO
    @(negedge qclk);
    req = 1'b1; we = 1'b1; addr = SLV_ADDR; wdata = 16'o000777;
    @(negedge qclk);
    req = 1'b0;
    n = 0;
    while (!tdout && n < 100) begin @(negedge qclk); n++; end
    check_eq("rst_reached_dout", {31'b0, tdout}, 32'd1);
    reset_n = 1'b0;
    @(negedge qclk);
    check_eq("rst_outs_low", {21'b0, outs, nxm}, 32'd0);
    check_eq("rst_rdata_zero", {16'b0, rdata}, 32'd0);
    @(negedge qclk);
    reset_n = 1'b1;
    repeat (2) @(negedge qclk);
    arb_force = 1'b1;
    repeat (4) @(negedge qclk);
    check_eq("idle_dmgo_high", {31'b0, tdmgo}, 32'd1);
    arb_force = 1'b0;
    repeat (4) @(negedge qclk);
    check_eq("idle_dmgo_low", {31'b0, tdmgo}, 32'd0);

    check_eq("protocol_violations", viol, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
